// File: rtl/noc_ni_depacketizer_if.sv
// Flit-level constants and the router-to-NI flit link.
// Header flits carry marker, source X/Y, destination X/Y and a second marker field.
package noc_ni_pkg;
    localparam int Noc_Data_Width   = 32;
    localparam int Noc_VC_Channel   = 2;
    localparam int Noc_VC_W         = $clog2(Noc_VC_Channel);
    localparam int Noc_ID_X_Width   = 4;
    localparam int Noc_ID_Y_Width   = 4;
    localparam int Noc_Point_H      = 28;
    localparam int Noc_Source_Point = 20;
    localparam int Axi_Len_Point    = 12;
    localparam int Noc_Point_E      = 8;
    localparam logic [Noc_Data_Width-Noc_Point_H-1:0] Noc_Head_H = 4'hE;
    localparam logic [Noc_Data_Width-Noc_Point_H-1:0] Noc_Tail_H = 4'hD;
    localparam logic [Axi_Len_Point-Noc_Point_E-1:0]  Noc_Head_E = 4'hA;
    localparam logic [Axi_Len_Point-Noc_Point_E-1:0]  Noc_Tail_E = 4'h5;
endpackage

interface Noc_flit_interface;
    import noc_ni_pkg::*;

    logic [Noc_Data_Width-1:0] flit;
    logic [Noc_VC_Channel-1:0] valid;
    logic [Noc_VC_Channel-1:0] ready;
    logic [Noc_VC_Channel-1:0] vc_ready;

    modport sender   (output flit, valid, input  ready, vc_ready);
    modport receiver (input  flit, valid, output ready, vc_ready);
    modport master   (output flit, valid, input  ready, vc_ready);
    modport slave    (input  flit, valid, output ready, vc_ready);
endinterface

// File: rtl/noc_ni_depacketizer.sv
// NoC ejection port: per-VC flit FIFOs feeding a one-packet-at-a-time reassembly FSM.
// Optional destination filtering is compiled in with NOC_DEPACK_DEST_CHECK_EN.
module noc_ni_depacketizer
    import noc_ni_pkg::*;
#(
    parameter logic [Noc_ID_X_Width-1:0] X_ID       = '0,
    parameter logic [Noc_ID_Y_Width-1:0] Y_ID       = '0,
    parameter int                        FIFO_DEPTH = 4
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    Noc_flit_interface.receiver        noc_receiver_if,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [Noc_Data_Width-1:0]  out_data,
    output logic [Noc_ID_X_Width-1:0]  out_src_x,
    output logic [Noc_ID_Y_Width-1:0]  out_src_y,
    output logic [Noc_VC_W-1:0]        out_vc,
    output logic                       out_last,
    output logic                       err_format,
    output logic                       err_dest
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int VC    = Noc_VC_Channel;

    typedef logic [Noc_Data_Width-1:0] flit_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_FIRST,
        S_BODY,
        S_LAST
`ifdef NOC_DEPACK_DEST_CHECK_EN
        , S_DROP
`endif
    } state_t;

    function automatic logic is_head(input flit_t f);
        return (f[Noc_Data_Width-1:Noc_Point_H] == Noc_Head_H) &&
               (f[Axi_Len_Point-1:Noc_Point_E] == Noc_Head_E);
    endfunction

    function automatic logic is_tail(input flit_t f);
        return (f[Noc_Data_Width-1:Noc_Point_H] == Noc_Tail_H) &&
               (f[Axi_Len_Point-1:Noc_Point_E] == Noc_Tail_E);
    endfunction

    logic [VC-1:0]     w_wr_en;
    logic              w_wr_found;
    logic              w_wr_multi;
    logic              w_wr_ovf;
    logic [VC-1:0]     w_push;
    logic [VC-1:0]     w_pop;
    logic [VC-1:0]     w_empty;
    logic [VC-1:0]     w_full;
    flit_t             w_head [VC];
    logic [CNT_W-1:0]  w_count_next [VC];
    logic [VC-1:0]     r_ready;
    logic [VC-1:0]     r_vc_ready;

    state_t                    r_state, w_state_next;
    logic [Noc_VC_W-1:0]       r_lock_vc, w_lock_vc_next;
    logic [Noc_VC_W-1:0]       r_rr_ptr, w_rr_next;
    flit_t                     r_stage, w_stage_next;
    logic [Noc_ID_X_Width-1:0] r_src_x, w_src_x_next;
    logic [Noc_ID_Y_Width-1:0] r_src_y, w_src_y_next;
    logic                      r_err_format;
    logic                      w_err_fmt_rd;
    logic                      w_pop_lock;
    logic                      w_out_valid;
    logic                      w_out_last;
    logic [Noc_VC_W-1:0]       w_sel_vc;
    logic                      w_sel_found;
    flit_t                     w_cur;
    logic                      w_cur_avail;

    // Write side: only the lowest asserted valid is accepted per cycle.
    always_comb begin
        w_wr_en    = '0;
        w_wr_found = 1'b0;
        w_wr_multi = 1'b0;
        for (int v = 0; v < VC; v++) begin
            if (noc_receiver_if.valid[v]) begin
                if (!w_wr_found) begin
                    w_wr_en[v] = 1'b1;
                    w_wr_found = 1'b1;
                end else begin
                    w_wr_multi = 1'b1;
                end
            end
        end
    end

    assign w_wr_ovf = |(w_wr_en & w_full);

    for (genvar gi = 0; gi < VC; gi++) begin : g_vc
        flit_t            r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;
        logic [CNT_W-1:0] r_count;

        always_ff @(posedge noc_clk) begin
            if (w_push[gi]) begin
                r_mem[r_wr_ptr] <= noc_receiver_if.flit;
            end
        end

        always_ff @(posedge noc_clk or negedge noc_rst_n) begin
            if (!noc_rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= w_count_next[gi];
            end
        end

        assign w_count_next[gi] = r_count + CNT_W'(w_push[gi]) - CNT_W'(w_pop[gi]);
        assign w_head[gi]       = r_mem[r_rd_ptr];
        assign w_empty[gi]      = (r_count == '0);
        assign w_full[gi]       = (r_count == CNT_W'(FIFO_DEPTH));
        assign w_push[gi]       = w_wr_en[gi] && !w_full[gi];
        assign w_pop[gi]        = w_pop_lock && (r_lock_vc == Noc_VC_W'(gi));
    end

    // ready keeps one slot spare for the flit the router launched before seeing it drop.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_ready    <= '1;
            r_vc_ready <= '1;
        end else begin
            for (int v = 0; v < VC; v++) begin
                r_ready[v]    <= (w_count_next[v] <= CNT_W'(FIFO_DEPTH - 2));
                r_vc_ready[v] <= (w_count_next[v] == '0) &&
                                 !((w_state_next != S_IDLE) && (w_lock_vc_next == Noc_VC_W'(v)));
            end
        end
    end

    assign noc_receiver_if.ready    = r_ready;
    assign noc_receiver_if.vc_ready = r_vc_ready;

    // Round-robin pick of a non-empty FIFO, starting at r_rr_ptr.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_vc    = r_rr_ptr;
        for (int k = 0; k < VC; k++) begin
            if (!w_sel_found && !w_empty[(int'(r_rr_ptr) + k) % VC]) begin
                w_sel_found = 1'b1;
                w_sel_vc    = Noc_VC_W'((int'(r_rr_ptr) + k) % VC);
            end
        end
    end

    assign w_cur       = w_head[r_lock_vc];
    assign w_cur_avail = !w_empty[r_lock_vc];

`ifdef NOC_DEPACK_DEST_CHECK_EN
    logic r_err_dest, w_err_dest_next;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_lock_vc_next = r_lock_vc;
        w_rr_next      = r_rr_ptr;
        w_stage_next   = r_stage;
        w_src_x_next   = r_src_x;
        w_src_y_next   = r_src_y;
        w_pop_lock     = 1'b0;
        w_err_fmt_rd   = 1'b0;
        w_out_valid    = 1'b0;
        w_out_last     = 1'b0;
`ifdef NOC_DEPACK_DEST_CHECK_EN
        w_err_dest_next = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_lock_vc_next = w_sel_vc;
                    w_rr_next      = Noc_VC_W'((int'(w_sel_vc) + 1) % VC);
                    w_state_next   = S_HEAD;
                end
            end
            S_HEAD: begin
                if (w_cur_avail) begin
                    w_pop_lock = 1'b1;
                    if (!is_head(w_cur)) begin
                        w_err_fmt_rd = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_src_x_next = w_cur[Noc_Point_H-1 -: Noc_ID_X_Width];
                        w_src_y_next = w_cur[Noc_Point_H-Noc_ID_X_Width-1 -: Noc_ID_Y_Width];
`ifdef NOC_DEPACK_DEST_CHECK_EN
                        if ((w_cur[Noc_Source_Point-1 -: Noc_ID_X_Width] != X_ID) ||
                            (w_cur[Noc_Source_Point-Noc_ID_X_Width-1 -: Noc_ID_Y_Width] != Y_ID)) begin
                            w_err_dest_next = 1'b1;
                            w_state_next    = S_DROP;
                        end else begin
                            w_state_next = S_FIRST;
                        end
`else
                        w_state_next = S_FIRST;
`endif
                    end
                end
            end
            S_FIRST: begin
                if (w_cur_avail) begin
                    if (is_head(w_cur)) begin
                        w_err_fmt_rd = 1'b1;
                        w_state_next = S_HEAD;
                    end else if (is_tail(w_cur)) begin
                        w_pop_lock   = 1'b1;
                        w_err_fmt_rd = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_pop_lock   = 1'b1;
                        w_stage_next = w_cur;
                        w_state_next = S_BODY;
                    end
                end
            end
            S_BODY: begin
                // The staged word is only offered once the next flit proves it is not the last one.
                if (w_cur_avail) begin
                    if (is_head(w_cur)) begin
                        w_err_fmt_rd = 1'b1;
                        w_state_next = S_HEAD;
                    end else if (is_tail(w_cur)) begin
                        w_pop_lock   = 1'b1;
                        w_state_next = S_LAST;
                    end else begin
                        w_out_valid = 1'b1;
                        if (out_ready) begin
                            w_pop_lock   = 1'b1;
                            w_stage_next = w_cur;
                        end
                    end
                end
            end
            S_LAST: begin
                w_out_valid = 1'b1;
                w_out_last  = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
`ifdef NOC_DEPACK_DEST_CHECK_EN
            S_DROP: begin
                if (w_cur_avail) begin
                    if (is_head(w_cur)) begin
                        w_state_next = S_HEAD;
                    end else begin
                        w_pop_lock = 1'b1;
                        if (is_tail(w_cur)) w_state_next = S_IDLE;
                    end
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_state      <= S_IDLE;
            r_lock_vc    <= '0;
            r_rr_ptr     <= '0;
            r_stage      <= '0;
            r_src_x      <= '0;
            r_src_y      <= '0;
            r_err_format <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_lock_vc    <= w_lock_vc_next;
            r_rr_ptr     <= w_rr_next;
            r_stage      <= w_stage_next;
            r_src_x      <= w_src_x_next;
            r_src_y      <= w_src_y_next;
            r_err_format <= w_err_fmt_rd | w_wr_multi | w_wr_ovf;
        end
    end

`ifdef NOC_DEPACK_DEST_CHECK_EN
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) r_err_dest <= 1'b0;
        else            r_err_dest <= w_err_dest_next;
    end
    assign err_dest = r_err_dest;
`else
    assign err_dest = 1'b0;
`endif

    assign out_valid  = w_out_valid;
    assign out_last   = w_out_last;
    assign out_data   = r_stage;
    assign out_src_x  = r_src_x;
    assign out_src_y  = r_src_y;
    assign out_vc     = r_lock_vc;
    assign err_format = r_err_format;

endmodule
